// File: rtl/axi_lite_wr_rd_checker.sv
// AXI4-Lite bring-up master: writes C_NUM_WORDS generated words and reads each back, reporting pass/errors.
// Latency: 5 cycles per word against a zero-wait slave, plus 1 DONE cycle (4 words -> done 21 cycles after start).
// Backpressure: every channel waits on its handshake; a phase stalled for C_TIMEOUT cycles aborts the run.
module axi_lite_wr_rd_checker #(
  parameter int                              C_M_AXI_ADDR_WIDTH = 32,
  parameter int                              C_M_AXI_DATA_WIDTH = 32,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0]   C_BASE_ADDR        = '0,
  parameter int                              C_NUM_WORDS        = 4,
  parameter logic [C_M_AXI_DATA_WIDTH-1:0]   C_STEP             = 32'h0101_0101,
  parameter int                              C_TIMEOUT          = 1023
) (
  input  logic                              m00_axi_aclk,
  input  logic                              m00_axi_aresetn,
  input  logic                              start,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     seed,
  output logic                              busy,
  output logic                              done,
  output logic                              pass,
  output logic [7:0]                        err_count,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     fail_addr,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     m00_axi_awaddr,
  output logic [2:0]                        m00_axi_awprot,
  output logic                              m00_axi_awvalid,
  input  logic                              m00_axi_awready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     m00_axi_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   m00_axi_wstrb,
  output logic                              m00_axi_wvalid,
  input  logic                              m00_axi_wready,
  input  logic [1:0]                        m00_axi_bresp,
  input  logic                              m00_axi_bvalid,
  output logic                              m00_axi_bready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     m00_axi_araddr,
  output logic [2:0]                        m00_axi_arprot,
  output logic                              m00_axi_arvalid,
  input  logic                              m00_axi_arready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     m00_axi_rdata,
  input  logic [1:0]                        m00_axi_rresp,
  input  logic                              m00_axi_rvalid,
  output logic                              m00_axi_rready
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_WAIT_B, S_RD, S_WAIT_R, S_CHECK, S_DONE
  } state_t;

  localparam logic [31:0] TMO_LAST = 32'(C_TIMEOUT - 1);
  localparam logic [7:0]  LAST_K   = 8'(C_NUM_WORDS - 1);

  state_t                          r_state;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   r_addr;
  logic [C_M_AXI_DATA_WIDTH-1:0]   r_data;
  logic [7:0]                      r_k;
  logic [31:0]                     r_tmo;
  logic                            r_aw_done, r_w_done;
  logic                            r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;
  logic [1:0]                      r_bresp, r_rresp;
  logic [C_M_AXI_DATA_WIDTH-1:0]   r_rdata;
  logic                            r_busy, r_done, r_pass;
  logic [7:0]                      r_err_count;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   r_fail_addr;

  logic       w_aw_ok, w_w_ok, w_in_phase, w_phase_done, w_abort, w_word_bad, w_fail, w_last;
  logic [7:0] w_err_inc;

  // Phase completion, timeout abort and per-word failure decisions
  always_comb begin
    w_aw_ok      = r_aw_done | (r_awvalid & m00_axi_awready);
    w_w_ok       = r_w_done  | (r_wvalid  & m00_axi_wready);
    w_in_phase   = 1'b1;
    w_phase_done = 1'b0;
    case (r_state)
      S_WR:     w_phase_done = w_aw_ok & w_w_ok;
      S_WAIT_B: w_phase_done = m00_axi_bvalid;
      S_RD:     w_phase_done = m00_axi_arready;
      S_WAIT_R: w_phase_done = m00_axi_rvalid;
      default:  w_in_phase   = 1'b0;
    endcase
    w_abort    = w_in_phase & ~w_phase_done & (r_tmo == TMO_LAST);
    // Only OKAY passes; EXOKAY is not expected from a plain register slave
    w_word_bad = (r_bresp != 2'b00) | (r_rresp != 2'b00) | (r_rdata != r_data);
    w_fail     = w_abort | ((r_state == S_CHECK) & w_word_bad);
    w_last     = (r_k == LAST_K);
    w_err_inc  = (r_err_count == 8'hFF) ? 8'hFF : r_err_count + 8'd1;
  end

  // Run sequencer with registered channel controls and result registers
  always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
    if (!m00_axi_aresetn) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_data      <= '0;
      r_k         <= '0;
      r_tmo       <= '0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_bresp     <= '0;
      r_rresp     <= '0;
      r_rdata     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_err_count <= '0;
      r_fail_addr <= '0;
    end else begin
      r_done <= 1'b0;
      r_tmo  <= w_in_phase ? r_tmo + 32'd1 : 32'd0;
      if (w_fail) begin
        r_err_count <= w_err_inc;
        if (r_err_count == 8'd0) r_fail_addr <= r_addr;
      end
      if (w_abort) begin
        // Bring-up escape hatch: valids are withdrawn without a handshake
        r_awvalid <= 1'b0;
        r_wvalid  <= 1'b0;
        r_bready  <= 1'b0;
        r_arvalid <= 1'b0;
        r_rready  <= 1'b0;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
        r_tmo     <= '0;
        r_busy    <= 1'b0;
        r_done    <= 1'b1;
        r_pass    <= 1'b0;
        r_state   <= S_DONE;
      end else begin
        case (r_state)
          S_IDLE: if (start) begin
            r_addr      <= C_BASE_ADDR;
            r_data      <= seed;
            r_k         <= '0;
            r_err_count <= '0;
            r_pass      <= 1'b0;
            r_fail_addr <= '0;
            r_busy      <= 1'b1;
            r_awvalid   <= 1'b1;
            r_wvalid    <= 1'b1;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_tmo       <= '0;
            r_state     <= S_WR;
          end
          S_WR: begin
            if (r_awvalid & m00_axi_awready) begin
              r_awvalid <= 1'b0;
              r_aw_done <= 1'b1;
            end
            if (r_wvalid & m00_axi_wready) begin
              r_wvalid <= 1'b0;
              r_w_done <= 1'b1;
            end
            if (w_aw_ok & w_w_ok) begin
              r_aw_done <= 1'b0;
              r_w_done  <= 1'b0;
              r_bready  <= 1'b1;
              r_tmo     <= '0;
              r_state   <= S_WAIT_B;
            end
          end
          S_WAIT_B: if (m00_axi_bvalid) begin
            r_bresp   <= m00_axi_bresp;
            r_bready  <= 1'b0;
            r_arvalid <= 1'b1;
            r_tmo     <= '0;
            r_state   <= S_RD;
          end
          S_RD: if (m00_axi_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_tmo     <= '0;
            r_state   <= S_WAIT_R;
          end
          S_WAIT_R: if (m00_axi_rvalid) begin
            r_rdata  <= m00_axi_rdata;
            r_rresp  <= m00_axi_rresp;
            r_rready <= 1'b0;
            r_tmo    <= '0;
            r_state  <= S_CHECK;
          end
          S_CHECK: begin
            if (w_last) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= ~w_fail & (r_err_count == 8'd0);
              r_state <= S_DONE;
            end else begin
              r_k       <= r_k + 8'd1;
              r_addr    <= r_addr + C_M_AXI_ADDR_WIDTH'(4);
              r_data    <= r_data + C_STEP;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= S_WR;
            end
          end
          // start arriving alongside the done pulse is deliberately dropped here
          S_DONE:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign busy            = r_busy;
  assign done            = r_done;
  assign pass            = r_pass;
  assign err_count       = r_err_count;
  assign fail_addr       = r_fail_addr;
  assign m00_axi_awaddr  = r_addr;
  assign m00_axi_awprot  = 3'b000;
  assign m00_axi_awvalid = r_awvalid;
  assign m00_axi_wdata   = r_data;
  assign m00_axi_wstrb   = '1;
  assign m00_axi_wvalid  = r_wvalid;
  assign m00_axi_bready  = r_bready;
  assign m00_axi_araddr  = r_addr;
  assign m00_axi_arprot  = 3'b000;
  assign m00_axi_arvalid = r_arvalid;
  assign m00_axi_rready  = r_rready;

endmodule
